// File: rtl/xmult_stream_unit.sv
// Load/compute/send engine: buffers N elements of X, computes Y[i] = coef*X[i]^2 (mod 2**DATA_W)
// and streams Y out under valid/ready handshakes.
module xmult_stream_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   n_elems,
  input  logic [DATA_W-1:0] coef,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] x_data,
  output logic              x_ready,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  input  logic              y_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int              CNT_W   = ADDR_W + 2;
  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_N = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] N_ONE   = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(MUL_LAT);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_SEND, S_DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem_x [DEPTH];
  logic [DATA_W-1:0] mem_y [DEPTH];

  logic [ADDR_W:0]   n_q;
  logic [DATA_W-1:0] coef_q;
  logic [ADDR_W:0]   wr_cnt;
  logic [CNT_W-1:0]  comp_cnt;
  logic [ADDR_W:0]   yw_cnt;
  logic [ADDR_W:0]   rd_ptr;
  logic              err_q;

  logic [DATA_W-1:0] x_p0;
  logic [DATA_W-1:0] prod_p [1:MUL_LAT];
  logic [MUL_LAT:0]  vld_p;

  logic start_ok, n_bad, x_fire, load_last, comp_end, rd_x_en;
  logic y_fire, send_last, y_load;

  // Wrapping product: low DATA_W bits of coef * x * x.
  function automatic logic [DATA_W-1:0] mul_wrap(input logic [DATA_W-1:0] c,
                                                 input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] sq;
    sq = x * x;
    return sq * c;
  endfunction

  assign start_ok  = (state == S_IDLE) && start;
  assign n_bad     = n_elems > DEPTH_N;
  assign x_fire    = x_valid && x_ready;
  assign load_last = x_fire && (wr_cnt == n_q - N_ONE);
  assign rd_x_en   = (state == S_COMP) && (comp_cnt < {1'b0, n_q});
  assign comp_end  = comp_cnt == ({1'b0, n_q} + LAT_C);
  assign y_fire    = y_valid && y_ready;
  assign send_last = y_fire && (rd_ptr == n_q);
  // Prefetch the next Y whenever the output slot is empty or being drained.
  assign y_load    = (state == S_SEND) && (!y_valid || y_ready) && (rd_ptr != n_q);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !n_bad) state_nxt = (n_elems == '0) ? S_DONE : S_LOAD;
      S_LOAD: if (load_last) state_nxt = S_COMP;
      S_COMP: if (comp_end)  state_nxt = S_SEND;
      S_SEND: if (send_last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    x_ready = (state == S_LOAD);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    err     = err_q;
  end

  always_ff @(posedge clk) begin
    if (start_ok) begin
      n_q    <= n_elems;
      coef_q <= coef;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q    <= 1'b0;
      wr_cnt   <= '0;
      comp_cnt <= '0;
      yw_cnt   <= '0;
      rd_ptr   <= '0;
      vld_p    <= '0;
      y_valid  <= 1'b0;
    end else begin
      err_q <= start_ok && n_bad;
      if (state != S_LOAD) wr_cnt <= '0;
      else if (x_fire)     wr_cnt <= wr_cnt + N_ONE;
      if (state != S_COMP) comp_cnt <= '0;
      else                 comp_cnt <= comp_cnt + C_ONE;
      if (state != S_COMP)        yw_cnt <= '0;
      else if (vld_p[MUL_LAT])    yw_cnt <= yw_cnt + N_ONE;
      vld_p <= {vld_p[MUL_LAT-1:0], rd_x_en};
      if (state != S_SEND) rd_ptr <= '0;
      else if (y_load)     rd_ptr <= rd_ptr + N_ONE;
      if (state != S_SEND || send_last) y_valid <= 1'b0;
      else if (y_load)                  y_valid <= 1'b1;
    end
  end

  // Load stage: X buffer write port
  always_ff @(posedge clk) begin
    if (x_fire) mem_x[wr_cnt[ADDR_W-1:0]] <= x_data;
  end

  // Stage p0: synchronous X buffer read
  always_ff @(posedge clk) begin
    if (rd_x_en) x_p0 <= mem_x[comp_cnt[ADDR_W-1:0]];
  end

  // Stages p1..pMUL_LAT: multiplier pipeline
  always_ff @(posedge clk) begin
    prod_p[1] <= mul_wrap(coef_q, x_p0);
    for (int k = 2; k <= MUL_LAT; k++) prod_p[k] <= prod_p[k-1];
  end

  // Write-back stage: Y buffer write port
  always_ff @(posedge clk) begin
    if (vld_p[MUL_LAT]) mem_y[yw_cnt[ADDR_W-1:0]] <= prod_p[MUL_LAT];
  end

  // Send stage: Y buffer read straight into the output register
  always_ff @(posedge clk) begin
    if (reset)       y_data <= '0;
    else if (y_load) y_data <= mem_y[rd_ptr[ADDR_W-1:0]];
  end

endmodule
